// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NREQ local requesters onto one APB bus,
// runs SETUP/ACCESS, and returns read data or a timeout error to the winner.
module apb_rr_master #(
  parameter int NREQ      = 2,
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
  input  logic [NREQ*DATAWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]           req_ack,
  output logic [NREQ-1:0]           rsp_done,
  output logic [DATAWIDTH-1:0]      rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRWIDTH-1:0]      paddr,
  output logic [DATAWIDTH-1:0]      pwdata,
  input  logic [DATAWIDTH-1:0]      prdata,
  input  logic                      pready
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDRWIDTH-1:0]  paddr_q, paddr_d;
  logic [DATAWIDTH-1:0]  pwdata_q, pwdata_d;
  logic [NREQ-1:0]       req_ack_q, req_ack_d;
  logic [NREQ-1:0]       rsp_done_q, rsp_done_d;
  logic [DATAWIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic [ADDRWIDTH-1:0]  addr_arr  [NREQ];
  logic [DATAWIDTH-1:0]  wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDRWIDTH +: ADDRWIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATAWIDTH +: DATAWIDTH];
  end

  // Round-robin pick: lowest requester above last_grant, else wrap to lowest overall.
  logic          hi_found, lo_found, any_req;
  logic [GW-1:0] hi_win, lo_win, win;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (req_valid[j]) begin
        if (!hi_found && (GW'(j) > last_grant_q)) begin
          hi_found = 1'b1;
          hi_win   = GW'(j);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_win   = GW'(j);
        end
      end
    end
    any_req = lo_found;
    win     = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    req_ack_d    = '0;
    rsp_done_d   = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    tmo_d        = tmo_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d        = win;
          last_grant_d   = win;
          req_ack_d[win] = 1'b1;
          paddr_d        = addr_arr[win];
          pwrite_d       = req_write[win];
          pwdata_d       = wdata_arr[win];
          psel_d         = 1'b1;
          penable_d      = 1'b0;
          state_d        = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        tmo_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          rsp_rdata_d         = pwrite_q ? '0 : prdata;
          rsp_err_d           = 1'b0;
          rsp_done_d[grant_q] = 1'b1;
          state_d             = DONE;
        end else begin
          if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
          end
          // Counter equal to the limit here means TIMEOUT+1 ACCESS cycles elapsed.
          if ((TIMEOUT != 0) && (tmo_q == TMO_LIM)) begin
            psel_d              = 1'b0;
            penable_d           = 1'b0;
            rsp_rdata_d         = '0;
            rsp_err_d           = 1'b1;
            rsp_done_d[grant_q] = 1'b1;
            state_d             = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      req_ack_q    <= '0;
      rsp_done_q   <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      last_grant_q <= GW'(NREQ - 1);
      grant_q      <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      req_ack_q    <= req_ack_d;
      rsp_done_q   <= rsp_done_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      tmo_q        <= tmo_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign req_ack   = req_ack_q;
  assign rsp_done  = rsp_done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: APB slave model, response scoreboard,
// and per-scenario timeline checks.
module tb_apb_rr_master;
  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TMO  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_write = '0;
  logic [NREQ*AW-1:0] req_addr  = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    rsp_done;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               psel, penable, pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata = '0;
  logic               pready = 1'b0;

  int checks = 0;
  int errors = 0;
  int slv_waits = 0;
  int acc_cnt = 0;
  logic [DW-1:0] mem [256];

  typedef struct {
    int         idx;
    logic [DW-1:0] rdata;
    logic       err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [NREQ-1:0] mon_vec;

  apb_rr_master #(
    .NREQ(NREQ), .ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_done(rsp_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  // APB slave: ready after slv_waits extra ACCESS cycles; prdata always driven.
  always @(negedge clk) begin
    if (psel && penable) begin
      prdata = mem[paddr];
      if (acc_cnt == slv_waits) begin
        pready = 1'b1;
        if (pwrite) mem[paddr] = pwdata;
      end else begin
        pready = 1'b0;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'b0;
    end
  end

  // Scoreboard: every rsp_done pulse consumes one expected response.
  always @(negedge clk) begin
    if (rst && (rsp_done !== '0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got %b want no response", rsp_done);
      end else begin
        mon_e = sb.pop_front();
        mon_vec = '0;
        mon_vec[mon_e.idx] = 1'b1;
        if (rsp_done !== mon_vec) begin
          errors++;
          $display("FAIL done_idx got %b want %b", rsp_done, mon_vec);
        end
        checks++;
        if (rsp_rdata !== mon_e.rdata) begin
          errors++;
          $display("FAIL rsp_rdata got %h want %h", rsp_rdata, mon_e.rdata);
        end
        checks++;
        if (rsp_err !== mon_e.err) begin
          errors++;
          $display("FAIL rsp_err got %b want %b", rsp_err, mon_e.err);
        end
        $display("rsp idx=%0d rdata=%h err=%b", mon_e.idx, rsp_rdata, rsp_err);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (psel !== 1'b0) begin errors++; $display("FAIL reset_psel got %b want 0", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL reset_penable got %b want 0", penable); end
    checks++; if (pwrite !== 1'b0) begin errors++; $display("FAIL reset_pwrite got %b want 0", pwrite); end
    checks++; if (paddr !== '0) begin errors++; $display("FAIL reset_paddr got %h want 0", paddr); end
    checks++; if (pwdata !== '0) begin errors++; $display("FAIL reset_pwdata got %h want 0", pwdata); end
    checks++; if (req_ack !== '0) begin errors++; $display("FAIL reset_ack got %b want 0", req_ack); end
    checks++; if (rsp_done !== '0) begin errors++; $display("FAIL reset_done got %b want 0", rsp_done); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
    $display("reset checked");
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] wd;
    logic [1:0] e_ack, e_done;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      wd = (t == 0) ? 32'hDEADBEEF : 32'h0;
      set_req(0, (t == 0), 8'h10, wd);
      sb.push_back('{0, (t == 0) ? 32'h0 : 32'hDEADBEEF, 1'b0});
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        e_ack  = (c == 1) ? 2'b01 : 2'b00;
        e_done = (c == 3) ? 2'b01 : 2'b00;
        checks++; if (psel !== (c <= 2)) begin errors++; $display("FAIL wr_psel c%0d got %b want %b", c, psel, (c <= 2)); end
        checks++; if (penable !== (c == 2)) begin errors++; $display("FAIL wr_penable c%0d got %b want %b", c, penable, (c == 2)); end
        checks++; if (req_ack !== e_ack) begin errors++; $display("FAIL wr_ack c%0d got %b want %b", c, req_ack, e_ack); end
        checks++; if (rsp_done !== e_done) begin errors++; $display("FAIL wr_done c%0d got %b want %b", c, rsp_done, e_done); end
        if (c <= 2) begin
          checks++; if (paddr !== 8'h10) begin errors++; $display("FAIL wr_paddr c%0d got %h want 10", c, paddr); end
          checks++; if (pwdata !== wd) begin errors++; $display("FAIL wr_pwdata c%0d got %h want %h", c, pwdata, wd); end
          checks++; if (pwrite !== (t == 0)) begin errors++; $display("FAIL wr_pwrite c%0d got %b want %b", c, pwrite, (t == 0)); end
        end
        if (req_ack !== '0) req_valid = '0;
      end
      $display("write_read transfer %0d done", t);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL wr_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_fairness();
    int acks;
    logic [1:0] e_ack;
    apply_reset();
    @(negedge clk);
    set_req(0, 1'b0, 8'h10, 32'h0);
    set_req(1, 1'b0, 8'h44, 32'h0);
    for (int t = 0; t < 6; t++) begin
      sb.push_back('{t % 2, (t % 2 == 0) ? 32'hDEADBEEF : 32'hA5000044, 1'b0});
    end
    acks = 0;
    for (int c = 0; c < 80 && (acks < 6 || sb.size() > 0); c++) begin
      @(negedge clk);
      if (req_ack !== '0) begin
        e_ack = (acks % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (req_ack !== e_ack) begin errors++; $display("FAIL fair_ack n%0d got %b want %b", acks, req_ack, e_ack); end
        $display("fair ack %0d = %b", acks, req_ack);
        acks++;
        if (acks == 6) req_valid = '0;
      end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (req_ack !== '0) begin errors++; $display("FAIL fair_extra_ack got %b want 00", req_ack); end
    end
    checks++; if (acks != 6) begin errors++; $display("FAIL fair_ack_count got %0d want 6", acks); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fair_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_wait_states();
    int pen_cnt;
    logic [1:0] e_done, e_ack;
    slv_waits = 3;
    pen_cnt = 0;
    @(negedge clk);
    set_req(0, 1'b1, 8'h30, 32'h12345678);
    sb.push_back('{0, 32'h0, 1'b0});
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      e_ack  = (c == 1) ? 2'b01 : 2'b00;
      e_done = (c == 6) ? 2'b01 : 2'b00;
      if (penable === 1'b1) pen_cnt++;
      checks++; if (psel !== (c <= 5)) begin errors++; $display("FAIL ws_psel c%0d got %b want %b", c, psel, (c <= 5)); end
      checks++; if (penable !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL ws_penable c%0d got %b want %b", c, penable, (c >= 2 && c <= 5)); end
      checks++; if (req_ack !== e_ack) begin errors++; $display("FAIL ws_ack c%0d got %b want %b", c, req_ack, e_ack); end
      checks++; if (rsp_done !== e_done) begin errors++; $display("FAIL ws_done c%0d got %b want %b", c, rsp_done, e_done); end
      if (c <= 5) begin
        checks++; if (paddr !== 8'h30) begin errors++; $display("FAIL ws_paddr c%0d got %h want 30", c, paddr); end
        checks++; if (pwdata !== 32'h12345678) begin errors++; $display("FAIL ws_pwdata c%0d got %h want 12345678", c, pwdata); end
      end
      if (req_ack !== '0) req_valid = '0;
    end
    checks++; if (pen_cnt != 4) begin errors++; $display("FAIL ws_penable_cycles got %0d want 4", pen_cnt); end
    $display("wait_states penable cycles %0d", pen_cnt);
    slv_waits = 0;
  endtask

  task automatic test_timeout();
    logic [1:0] e_done, e_ack;
    slv_waits = 1000;
    @(negedge clk);
    set_req(1, 1'b0, 8'h50, 32'h0);
    sb.push_back('{1, 32'h0, 1'b1});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      e_ack  = (c == 1) ? 2'b10 : 2'b00;
      e_done = (c == 3 + TMO) ? 2'b10 : 2'b00;
      checks++; if (psel !== (c <= 2 + TMO)) begin errors++; $display("FAIL to_psel c%0d got %b want %b", c, psel, (c <= 2 + TMO)); end
      checks++; if (penable !== (c >= 2 && c <= 2 + TMO)) begin errors++; $display("FAIL to_penable c%0d got %b want %b", c, penable, (c >= 2 && c <= 2 + TMO)); end
      checks++; if (req_ack !== e_ack) begin errors++; $display("FAIL to_ack c%0d got %b want %b", c, req_ack, e_ack); end
      checks++; if (rsp_done !== e_done) begin errors++; $display("FAIL to_done c%0d got %b want %b", c, rsp_done, e_done); end
      if (req_ack !== '0) req_valid = '0;
    end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL to_err_hold got %b want 1", rsp_err); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL to_rdata_hold got %h want 0", rsp_rdata); end
    slv_waits = 0;
    @(negedge clk);
    set_req(0, 1'b0, 8'h30, 32'h0);
    sb.push_back('{0, 32'h12345678, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      e_done = (c == 3) ? 2'b01 : 2'b00;
      checks++; if (rsp_done !== e_done) begin errors++; $display("FAIL to_next_done c%0d got %b want %b", c, rsp_done, e_done); end
      if (req_ack !== '0) req_valid = '0;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL to_pending got %0d want 0", sb.size()); end
    $display("timeout scenario done");
  endtask

  task automatic test_reset_mid();
    bit reached;
    slv_waits = 1000;
    reached = 1'b0;
    @(negedge clk);
    set_req(0, 1'b0, 8'h10, 32'h0);
    for (int k = 0; k < 20 && !reached; k++) begin
      @(negedge clk);
      if (req_ack !== '0) req_valid = '0;
      if (psel === 1'b1 && penable === 1'b1) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL rm_access got 0 want 1"); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (psel !== 1'b0) begin errors++; $display("FAIL rm_psel got %b want 0", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL rm_penable got %b want 0", penable); end
    checks++; if (rsp_done !== '0) begin errors++; $display("FAIL rm_done got %b want 0", rsp_done); end
    slv_waits = 0;
    set_req(0, 1'b0, 8'h10, 32'h0);
    set_req(1, 1'b0, 8'h44, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{0, 32'hDEADBEEF, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL rm_tie_ack got %b want 01", req_ack); end
      end
      if (req_ack !== '0) req_valid = '0;
    end
    @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rm_pending got %0d want 0", sb.size()); end
    $display("reset_mid scenario done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 | i;
    test_reset();
    test_write_read();
    test_fairness();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
